// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline stage register with a 2-entry skid
// buffer. Flush clears valid and control fields; the datapath payload is kept.
// A saturating counter tracks cycles where downstream back-pressures a valid entry.
module pipe_stage_elastic #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr
);

  // Occupancy doubles as the state encoding, so occ comes straight off the flop.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid_in;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_stall    = r_out_valid & ~out_ready;

  // Next-state and load-enable decode; flush overrides every transfer into the stage.
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid_in   = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_next   = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_next   = ST_TWO;
            w_load_skid_in = 1'b1;
          end else if (w_out_fire) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the drain path matters.
          if (w_out_fire) begin
            w_state_next     = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // State register plus registered valid/ready derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (w_state_next != ST_EMPTY);
      r_in_ready  <= (w_state_next != ST_TWO);
    end
  end

  // Entry payloads; data only moves on a real transfer so idle X on in_* never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
        r_skid_ctrl <= '0;
      end
      if (w_load_skid_in) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end
      if (flush) begin
        r_main_ctrl <= '0;
        r_skid_ctrl <= '0;
      end
    end
  end

  // Saturating back-pressure counter; clear wins over increment, flush is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_out_valid ? r_main_ctrl : '0;
  assign occ       = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: streaming, back-pressure, flush,
// stall counter saturation and asynchronous reset.
module tb_pipe_stage_elastic;

  localparam int DATA_W = 48;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_cnt_clr;

  int n_pass  = 0;
  int n_total = 0;
  logic [DATA_W-1:0] delivered[$];

  // Back-pressure table: inputs per cycle, expected state after the edge.
  int bp_v  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
  int bp_d  [8] = '{1, 2, 3, 3, 3, 3, 4, 0};
  int bp_r  [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
  int bp_occ[8] = '{1, 2, 2, 2, 1, 1, 1, 0};
  int bp_ir [8] = '{1, 0, 0, 0, 1, 1, 1, 1};
  int bp_od [8] = '{1, 1, 1, 1, 2, 3, 4, 4};

  pipe_stage_elastic #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .occ          (occ),
    .stall_cnt    (stall_cnt),
    .stall_cnt_clr(stall_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Record any transfer completing at the coming edge, then advance past it.
  task automatic step();
    if (out_valid && out_ready) delivered.push_back(out_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; stall_cnt_clr = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occ, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      in_data = DATA_W'(i);
      step();
      chk("stream_data", out_data, i);
      chk("stream_occ", occ, 1);
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_occ", occ, 0);
    chk("stream_stall", stall_cnt, 0);

    // Back-pressure
    delivered.delete();
    for (int i = 0; i < 8; i++) begin
      in_valid  = (bp_v[i] != 0);
      in_data   = DATA_W'(bp_d[i]);
      out_ready = (bp_r[i] != 0);
      step();
      chk("bp_occ", occ, bp_occ[i]);
      chk("bp_in_ready", in_ready, bp_ir[i]);
      chk("bp_out_data", out_data, bp_od[i]);
      if (i == 3) chk("bp_stall_cnt", stall_cnt, 3);
    end
    chk("bp_delivered_count", delivered.size(), 4);
    for (int i = 0; i < 4 && i < delivered.size(); i++)
      chk("bp_delivered_word", delivered[i], i + 1);
    stall_cnt_clr = 1'b1;
    step();
    stall_cnt_clr = 1'b0;
    chk("clr_stall", stall_cnt, 0);

    // Flush in TWO
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF;
    in_data = 48'hA;
    step();
    in_data = 48'hB;
    step();
    chk("fl2_occ_two", occ, 2);
    chk("fl2_ctrl_ff", out_ctrl, 8'hFF);
    flush = 1'b1; in_data = 48'hC;
    step();
    flush = 1'b0;
    chk("fl2_out_valid", out_valid, 0);
    chk("fl2_out_ctrl", out_ctrl, 0);
    chk("fl2_occ", occ, 0);
    chk("fl2_data_kept", out_data, 48'hA);
    chk("fl2_in_ready", in_ready, 1);
    in_data = 48'hD; in_ctrl = 8'h5A; out_ready = 1'b1;
    step();
    chk("fl2_d_data", out_data, 48'hD);
    chk("fl2_d_ctrl", out_ctrl, 8'h5A);
    chk("fl2_d_occ", occ, 1);
    in_valid = 1'b0;
    step();
    chk("fl2_empty", occ, 0);

    // Flush with out_fire, simultaneous input dropped
    out_ready = 1'b0; in_valid = 1'b1; in_data = 48'h7; in_ctrl = 8'h33;
    step();
    delivered.delete();
    flush = 1'b1; out_ready = 1'b1; in_data = 48'h8;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flo_delivered_count", delivered.size(), 1);
    if (delivered.size() > 0) chk("flo_delivered_word", delivered[0], 48'h7);
    chk("flo_occ", occ, 0);
    chk("flo_out_valid", out_valid, 0);
    step();
    chk("flo_input_dropped", occ, 0);

    // Stall counter saturation at 15
    stall_cnt_clr = 1'b1;
    step();
    stall_cnt_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 48'h9; in_ctrl = 8'h11;
    step();
    in_valid = 1'b0;
    chk("sc_start", stall_cnt, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 15) chk("sc_reach15", stall_cnt, 15);
    end
    chk("sc_saturated", stall_cnt, 15);
    stall_cnt_clr = 1'b1;
    step();
    stall_cnt_clr = 1'b0;
    chk("sc_clr", stall_cnt, 0);
    step();
    chk("sc_count1", stall_cnt, 1);
    step();
    chk("sc_count2", stall_cnt, 2);

    // Asynchronous reset while full
    in_valid = 1'b1; in_data = 48'h10;
    step();
    in_valid = 1'b0;
    chk("ar_occ_two", occ, 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_occ", occ, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_stall", stall_cnt, 0);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = 48'h11; in_ctrl = 8'h22; out_ready = 1'b1;
    step();
    chk("ar_post_data", out_data, 48'h11);
    chk("ar_post_ctrl", out_ctrl, 8'h22);
    chk("ar_post_occ", occ, 1);
    in_valid = 1'b0;
    step();
    chk("ar_post_empty", occ, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
